// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, LSB first, WIDTH cycles per result.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_shifted;

  full_adder u_cell (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; a one-bit adder has nothing to shift down.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign sum_shifted = fa_sum;
    end else begin : g_wide
      assign sum_shifted = {fa_sum, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_q <= c_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_shifted;
          carry_q <= fa_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            sum_out   <= sum_shifted;
            carry_out <= fa_carry;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8) with directed vectors.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         carry_out;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual={%0b,0x%0h} required=no_result", carry_out, sum_out);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({carry_out, sum_out} !== e) begin
          failures++;
          $display("FAIL result actual=0x%0h required=0x%0h", {carry_out, sum_out}, e);
        end else begin
          $display("ok   result value=0x%0h", e);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W:0] expv);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  initial begin
    int  bc;
    bit  got;
    int  idx[2];
    int  n;
    int  ndone;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    c_in  = 1'b0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum_out), 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x3C + 0x42 = 0x7E
    issue(8'h3C, 8'h42, 1'b0, 9'h07E);
    wait_done(bc, got);
    chk("t1_done_seen", 32'(got), 32'd1);
    chk("t1_busy_cycles", 32'(bc), 32'd8);
    chk("t1_busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done), 32'd0);

    // 0xFF + 0x01 = 0x100, then hold
    issue(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_done(bc, got);
    chk("t2_done_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold", 32'({carry_out, sum_out}), 32'h100);
    end

    // 0xA5 + 0x5A + 1 = 0x100
    issue(8'hA5, 8'h5A, 1'b1, 9'h100);
    wait_done(bc, got);
    chk("t3_done_seen", 32'(got), 32'd1);
    @(negedge clk);

    // start held high: operands change mid-SHIFT, picked up only at the DONE edge
    @(negedge clk);
    a_in  = 8'h10;
    b_in  = 8'h20;
    c_in  = 1'b0;
    start = 1'b1;
    exp_q.push_back(9'h030);
    @(posedge clk);
    #1;
    a_in = 8'h01;
    b_in = 8'h01;
    exp_q.push_back(9'h002);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        idx[n] = i;
        n++;
        if (n == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    if (n < 2) start = 1'b0;
    chk("t4_done_count", 32'(n), 32'd2);
    if (n == 2) chk("t4_done_spacing", 32'(idx[1] - idx[0]), 32'd9);
    @(negedge clk);

    // reset in the middle of 0xFF + 0xFF
    @(negedge clk);
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before_reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_sum_after_reset", 32'(sum_out), 32'd0);
    chk("t5_carry_after_reset", 32'(carry_out), 32'd0);
    chk("t5_busy_after_reset", 32'(busy), 32'd0);
    chk("t5_done_after_reset", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);

    issue(8'h01, 8'h02, 1'b0, 9'h003);
    wait_done(bc, got);
    chk("t5_done_seen", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that consumes the existing single-bit full_adder.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Uses one full_adder instance and a registered carry loop.
- Intended as the sequential stage built on the full-adder lab block; it trades WIDTH cycles of latency for one adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to begin an addition; sampled on the rising edge.
- a_in, input, WIDTH, operand A; captured on the accepting edge.
- b_in, input, WIDTH, operand B; captured on the accepting edge.
- c_in, input, 1, carry-in; captured on the accepting edge.
- busy, output, 1, high while state is SHIFT.
- done, output, 1, one-cycle pulse when the result is valid.
- sum_out, output, WIDTH, registered sum; held until the next result.
- carry_out, output, 1, registered final carry; held until the next result.

Behaviour:
- Reset: one clock and an asynchronous active-low reset, named clk and rst_n. The polarity and synchronicity are fixed.
  - rst_n low forces state to IDLE immediately and asynchronously.
  - It also clears the shift registers, carry_q, the bit counter, sum_out, carry_out, busy and done to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: load a_sr<=a_in, b_sr<=b_in, carry_q<=c_in, cnt<=0, then go to SHIFT.
- SHIFT, on each edge:
  - The full_adder computes on a_sr[0], b_sr[0] and carry_q.
  - The sum bit is shifted into the MSB of sum_sr (right shift).
  - a_sr and b_sr shift right by one; carry_q<=carry; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - sum_out<={sum bit, sum_sr[WIDTH-1:1]}, i.e. the complete sum.
    - carry_out<=carry.
    - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge: if start=1, reload exactly as in IDLE and go to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - done is high in the cycle beginning WIDTH rising edges after the edge that accepted start.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no reload and no effect on the running operation.
- a_in, b_in and c_in are don't-care except on the accepting edge.
- sum_out and carry_out change only on the final SHIFT edge or on reset. They are stable during SHIFT and keep the previous result.
- Arithmetic: {carry_out, sum_out} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1). No overflow flag.
- cnt width is $clog2(WIDTH+1). For WIDTH=1, SHIFT lasts one cycle.
- Reset mid-operation aborts the addition: no done pulse, and outputs read 0.
- Illegal state encodings return to IDLE.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
  - The default WIDTH constant.
- One sub-module: the existing full_adder, instantiated once as the bit cell (ports a, b, c, sum, carry).
- The FSM, shift registers, counter and output registers stay in serial_adder.

Test Plan:
- WIDTH=8, a_in=0x3C, b_in=0x42, c_in=0, start pulsed once -> busy high for 8 cycles, then done=1 for one cycle, sum_out=0x7E, carry_out=0.
- a_in=0xFF, b_in=0x01, c_in=0 -> sum_out=0x00, carry_out=1; the outputs hold through 5 further idle cycles.
- a_in=0xA5, b_in=0x5A, c_in=1 -> sum_out=0x00, carry_out=1.
- start held high continuously with operands 0x10+0x20, then 0x01+0x01 -> done pulses 9 cycles apart.
  - Results 0x30 then 0x02.
  - A second start asserted mid-SHIFT does not disturb the first result.
- rst_n pulled low mid-SHIFT (cycle 4 of 0xFF+0xFF) -> outputs immediately read 0 and state is IDLE.
  - No done pulse.
  - A following start with 0x01+0x02 yields 0x03.
